ex_stage: RTL
=============

# ex_stage

Execute stage of the sequential RISC-V core. It accepts one decoded integer instruction per cycle from decode over a valid/ready handshake and computes the RV64I ALU result: add/sub, shifts, compares and logic. It registers the result toward the memory/writeback stage, and a 2-entry skid buffer keeps `in_ready` a pure register output.

## Interface
- `XLEN`, 64: datapath width; only 64 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all held and incoming instructions this cycle.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage can accept; registered.
- `in_rs1`  in  64  operand A.
- `in_rs2`  in  64  register operand B.
- `in_imm`  in  64  sign-extended immediate.
- `in_use_imm`  in  1  operand B = `in_imm`, else `in_rs2`.
- `in_funct3`  in  3  RISC-V funct3.
- `in_funct7`  in  7  RISC-V funct7; bit 5 selects SUB/SRA.
- `in_word`  in  1  OP-32/OP-IMM-32 (W) instruction.
- `in_rd`  in  5  destination register.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts.
- `out_result`  out  64  ALU result.
- `out_rd`  out  5  destination register.

## Operation
- Operand B = `in_use_imm ? in_imm : in_rs2`.
- funct3 decoding:
  - 000: ADD. SUB only when `funct7[5]=1` and `in_use_imm=0`.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when `funct7[5]=1`.
  - 110: OR.
  - 111: AND.
- Shift amount = B[5:0]. Upper bits of B are ignored.
- SRA fills with A[63]. SRL fills with 0.
- SLT/SLTU produce 64'd1 or 64'd0.
- The result is computed combinationally from the accepted entry and captured into the output register.
- Skid buffer: main entry M drives `out_*`; spare entry S is used only when M is held.
  - Accept = `in_valid && in_ready`.
  - M frees when `!out_valid || out_ready`.
  - M free and S empty: accepted entry loads into M.
  - M held and S empty: accepted entry loads into S; `in_ready` deasserts next cycle.
  - M drains and S full: S moves into M and S empties; `in_ready` reasserts next cycle.
- Accept and drain in the same cycle with S empty: the new entry replaces M; no bubble.
- `in_ready` = !S_full, registered.
- Flush:
  - `flush=1` clears M and S and ignores any accept that cycle.
  - Next cycle: `out_valid=0`, `in_ready=1`.
  - Flush takes precedence over `out_ready`.
- Reset: `out_valid=0`, `in_ready=1`, `out_result=0`, `out_rd=0`, S empty.
- Reset mid-stall discards both entries.
- `out_result`/`out_rd` are stable while `out_valid && !out_ready`.

## Timing
- Latency 1 cycle: accepted at edge N, `out_valid` with the result after edge N.
- Throughput 1 per cycle while `out_ready=1`.
- Stall: at most one extra instruction is accepted after `out_ready` falls.
- No combinational path from `out_ready` or `in_valid` to `in_ready`.

## Configuration
- `EX_WORD_OPS_EN` defined: `in_word=1` enables ADDW/SUBW/SLLW/SRLW/SRAW.
  - Operates on A[31:0] and B[31:0].
  - Shift amount = B[4:0].
  - SRAW fills with A[31].
  - The 32-bit result is sign-extended to 64.
- `EX_WORD_OPS_EN` undefined: `in_word` is ignored and all ops are 64-bit. The W datapath is absent.

## Structure
- Package `ex_pkg`:
  - funct3 constants `F3_ADD` through `F3_AND`.
  - Skid entry struct holding operands, funct3, funct7, word flag, use_imm and rd.
  - `XLEN` localparam.
- Sub-module `ex_skid_buf`: generic 2-entry valid/ready skid buffer, parameterized on payload width, with flush. The ALU combinational logic lives in `ex_stage`.

## Test plan
- Reset, then `in_valid=0` for 3 cycles: `out_valid=0`, `in_ready=1`, `out_result=0`.
- SRA with A=0x8000_0000_0000_0000, B=4, `funct7[5]=1`: `out_result`=0xF800_0000_0000_0000 one cycle after accept. The same with SRL gives 0x0800_0000_0000_0000.
- SUB with A=5, B=7: result 0xFFFF_FFFF_FFFF_FFFE. `in_use_imm=1`, funct7=0x20, imm=7: ADD, result 12.
- Back-to-back: hold `out_ready=0`, issue ADDs with rd=1,2,3.
  - rd1 is in M and rd2 is in S.
  - `in_ready=0` from the next cycle; rd3 waits.
  - Raise `out_ready`: outputs rd1, rd2, rd3 in consecutive cycles.
- Flush with M and S full and `in_valid=1`: next cycle `out_valid=0`, `in_ready=1`, nothing from before the flush appears.
- With `EX_WORD_OPS_EN`: SRAW A=0x0000_0000_8000_0000, B=1 gives 0xFFFF_FFFF_C000_0000. ADDW 0x7FFF_FFFF + 1 gives 0xFFFF_FFFF_8000_0000.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the RV64I execute stage.
//   XLEN          datapath width (64 only)
//   F3_*          RISC-V funct3 opcodes for the integer ALU
//   ex_entry_t    decoded instruction as presented by decode
//   ex_result_t   ALU result plus destination, the payload held in the skid buffer
package ex_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            word;
    logic            use_imm;
    logic [4:0]      rd;
  } ex_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
  } ex_result_t;

endpackage

// File: rtl/ex_if.sv
// ex_if: decode->execute->writeback handshake bundle.
//   flush                         drop held and incoming instructions
//   in_valid/in_ready             decode handshake
//   in_rs1/in_rs2/in_imm/...      decoded instruction fields
//   out_valid/out_ready           writeback handshake
//   out_result/out_rd             registered ALU result and destination
// Modports: master = decode/writeback side, slave = ex_stage.
interface ex_if;
  import ex_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            in_use_imm;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic            in_word;
  logic [4:0]      in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;

  modport master (
    output flush, in_valid, in_rs1, in_rs2, in_imm, in_use_imm, in_funct3, in_funct7,
           in_word, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd
  );

  modport slave (
    input  flush, in_valid, in_rs1, in_rs2, in_imm, in_use_imm, in_funct3, in_funct7,
           in_word, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd
  );

endinterface

// File: rtl/ex_skid_buf.sv
// ex_skid_buf: generic 2-entry valid/ready skid buffer with flush.
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready/in_data     upstream side; in_ready is a pure register output
//   out_valid/out_ready/out_data  downstream side, driven from main entry M
// Spare entry S only fills when M is held; in_ready = !S full.
module ex_skid_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             m_valid_q, m_valid_d;
  logic [Width-1:0] m_data_q, m_data_d;
  logic             s_valid_q, s_valid_d;
  logic [Width-1:0] s_data_q, s_data_d;
  logic             accept;
  logic             m_free;

  assign accept = in_valid && !s_valid_q;
  assign m_free = !m_valid_q || out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      if (s_valid_q) begin
        // accept is impossible here: in_ready is low while S is full
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = accept;
        if (accept) m_data_d = in_data;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

  assign in_ready  = !s_valid_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV64I execute stage. Computes the integer ALU result of the instruction on
// the input handshake and registers it toward memory/writeback through a skid buffer.
//   clk, rst (sync, active-high)
//   bus (ex_if.slave): flush, in_* decode handshake and fields, out_* result handshake
// Build option: define EX_WORD_OPS_EN to enable ADDW/SUBW/SLLW/SRLW/SRAW on in_word;
// otherwise in_word is ignored and every op is 64-bit.
module ex_stage
  import ex_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ex_if.slave  bus
);

  ex_entry_t       entry;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [5:0]      shamt;
  logic            alt;
  logic            is_sub;
  logic [XLEN-1:0] res64;
  logic [XLEN-1:0] result;
  ex_result_t      in_res;
  ex_result_t      out_res;

  assign entry = '{
    rs1:     bus.in_rs1,
    rs2:     bus.in_rs2,
    imm:     bus.in_imm,
    funct3:  bus.in_funct3,
    funct7:  bus.in_funct7,
    word:    bus.in_word,
    use_imm: bus.in_use_imm,
    rd:      bus.in_rd
  };

  assign op_a   = entry.rs1;
  assign op_b   = entry.use_imm ? entry.imm : entry.rs2;
  assign shamt  = op_b[5:0];
  assign alt    = entry.funct7[5];
  // Immediate forms have no SUB; funct7 bits there belong to the immediate.
  assign is_sub = alt && !entry.use_imm;

  always_comb begin
    res64 = '0;
    case (entry.funct3)
      F3_ADD:  res64 = is_sub ? op_a - op_b : op_a + op_b;
      F3_SLL:  res64 = op_a << shamt;
      F3_SLT:  res64 = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      F3_SLTU: res64 = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      F3_XOR:  res64 = op_a ^ op_b;
      F3_SRL:  res64 = alt ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
      F3_OR:   res64 = op_a | op_b;
      F3_AND:  res64 = op_a & op_b;
      default: res64 = '0;
    endcase
  end

`ifdef EX_WORD_OPS_EN
  logic [31:0] a_w;
  logic [31:0] b_w;
  logic [4:0]  shamt_w;
  logic [31:0] res_w;
  logic        word_op;

  assign a_w     = op_a[31:0];
  assign b_w     = op_b[31:0];
  assign shamt_w = b_w[4:0];

  always_comb begin
    res_w = '0;
    case (entry.funct3)
      F3_ADD:  res_w = is_sub ? a_w - b_w : a_w + b_w;
      F3_SLL:  res_w = a_w << shamt_w;
      F3_SRL:  res_w = alt ? $unsigned($signed(a_w) >>> shamt_w) : a_w >> shamt_w;
      default: res_w = '0;
    endcase
  end

  // Only ADD/SUB/shift have W forms; other funct3 with in_word fall back to 64-bit.
  assign word_op = entry.word &&
                   (entry.funct3 == F3_ADD || entry.funct3 == F3_SLL ||
                    entry.funct3 == F3_SRL);
  assign result  = word_op ? {{32{res_w[31]}}, res_w} : res64;
`else
  logic unused_word;
  assign unused_word = entry.word;
  assign result      = res64;
`endif

  logic unused_funct7;
  assign unused_funct7 = ^{entry.funct7[6], entry.funct7[4:0]};

  assign in_res = '{result: result, rd: entry.rd};

  ex_skid_buf #(
    .Width($bits(ex_result_t))
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_res),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_res)
  );

  assign bus.out_result = out_res.result;
  assign bus.out_rd     = out_res.rd;

endmodule
